xbar_bridge_rr_arb: RTL and testbench

XBAR_BRIDGE_RR_ARB -- requirements
Module: xbar_bridge_rr_arb

---
 rtl/xbar_bridge_rr_arb.sv | 111 +++++++++++
 tb/tb_xbar_bridge_rr_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_bridge_rr_arb.sv
// Round-robin N:1 request arbiter in front of a single in-order target, with an
// ID FIFO that routes each response back to the requester that issued it.
module xbar_bridge_rr_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned PAYLOAD_W = 70,
    parameter int unsigned RDATA_W   = 32,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*PAYLOAD_W-1:0] payload_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic                       req_o,
    output logic [PAYLOAD_W-1:0]       payload_o,
    input  logic                       gnt_i,
    input  logic                       r_valid_i,
    input  logic [RDATA_W-1:0]         r_rdata_i,
    output logic [N_REQ-1:0]           r_valid_o,
    output logic [RDATA_W-1:0]         r_rdata_o,
    output logic [CNT_W-1:0]           outstanding_o,
    output logic                       err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  fifo_q [DEPTH];

    logic [ID_W-1:0]  winner;
    logic             found, full, empty, push, pop;
    logic [ID_W-1:0]  head;

    // Search starts at rr_ptr and wraps modulo N_REQ.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_REQ;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!found && req_i[k] && (k == idx)) begin
                    found  = 1'b1;
                    winner = ID_W'(k);
                end
            end
        end
    end

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        req_o = found && !full;
        push  = req_o && gnt_i;
        pop   = r_valid_i && !empty;
        head  = fifo_q[rd_ptr_q];

        payload_o = '0;
        gnt_o     = '0;
        r_valid_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req_o && (winner == ID_W'(k))) begin
                payload_o = payload_i[k*PAYLOAD_W +: PAYLOAD_W];
            end
            gnt_o[k]     = push && (winner == ID_W'(k));
            r_valid_o[k] = pop && (head == ID_W'(k));
        end
        r_rdata_o     = r_rdata_i;
        outstanding_o = count_q;
        err_o         = err_q;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            // Explicit wrap so non-power-of-two N_REQ never leaves a dead pointer value.
            rr_ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q | (r_valid_i & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // ID storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end
endmodule

// File: tb/tb_xbar_bridge_rr_arb.sv
// Randomised bench for xbar_bridge_rr_arb: a queue-based reference model predicts
// every cycle's outputs, a monitor process compares them against the DUT.
module tb_xbar_bridge_rr_arb;
    localparam int N  = 4;
    localparam int PW = 70;
    localparam int RW = 32;
    localparam int D  = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*PW-1:0] payload_i = '0;
    logic [N-1:0]    gnt_o;
    logic            req_o;
    logic [PW-1:0]   payload_o;
    logic            gnt_i = 1'b0;
    logic            r_valid_i = 1'b0;
    logic [RW-1:0]   r_rdata_i = '0;
    logic [N-1:0]    r_valid_o;
    logic [RW-1:0]   r_rdata_o;
    logic [CW-1:0]   outstanding_o;
    logic            err_o;

    // Second instance: three requesters, for the non-power-of-two wrap.
    logic [2:0]  req3 = '0;
    logic [23:0] pay3 = '0;
    logic [2:0]  gnt3_o;
    logic        req3_o;
    logic [7:0]  pay3_o;
    logic        gnt3 = 1'b0;
    logic        rv3 = 1'b0;
    logic [7:0]  rd3 = '0;
    logic [2:0]  rv3_o;
    logic [7:0]  rd3_o;
    logic [1:0]  out3_o;
    logic        err3_o;

    always #5 clk = ~clk;

    xbar_bridge_rr_arb #(.N_REQ(N), .PAYLOAD_W(PW), .RDATA_W(RW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .payload_i(payload_i), .gnt_o(gnt_o),
        .req_o(req_o), .payload_o(payload_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
        .r_rdata_i(r_rdata_i), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    xbar_bridge_rr_arb #(.N_REQ(3), .PAYLOAD_W(8), .RDATA_W(8), .DEPTH(2)) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .payload_i(pay3), .gnt_o(gnt3_o),
        .req_o(req3_o), .payload_o(pay3_o), .gnt_i(gnt3), .r_valid_i(rv3),
        .r_rdata_i(rd3), .r_valid_o(rv3_o), .r_rdata_o(rd3_o),
        .outstanding_o(out3_o), .err_o(err3_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic          req;
        logic [N-1:0]  gnt;
        logic [PW-1:0] pay;
        logic [N-1:0]  rv;
        logic [RW-1:0] rdata;
        logic [CW-1:0] outs;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: priority pointer, in-flight requester IDs, sticky error.
    int m_rr = 0;
    int m_q[$];
    bit m_err = 1'b0;

    task automatic drive(input bit r, input logic [N-1:0] rq, input bit g, input bit rv);
        exp_t e;
        int   winner;
        @(negedge clk);
        rst       = r;
        req_i     = rq;
        gnt_i     = g;
        r_valid_i = rv;
        r_rdata_i = $urandom;
        for (int b = 0; b < N*PW; b++) payload_i[b] = 1'($urandom);
        if (r) begin
            m_rr = 0;
            m_q.delete();
            m_err = 1'b0;
        end
        winner = -1;
        if (m_q.size() < D) begin
            for (int i = 0; i < N; i++) begin
                if (winner < 0 && rq[(m_rr + i) % N]) winner = (m_rr + i) % N;
            end
        end
        e.req   = (winner >= 0);
        e.gnt   = (e.req && g) ? N'(1 << winner) : '0;
        e.pay   = '0;
        if (e.req) e.pay = payload_i[winner*PW +: PW];
        e.rv    = (rv && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
        e.rdata = r_rdata_i;
        e.outs  = CW'(m_q.size());
        e.err   = m_err;
        exp_q.push_back(e);
        if (!r) begin
            if (rv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (e.req && g) begin
                m_q.push_back(winner);
                m_rr = (winner + 1) % N;
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_o", 128'(req_o), 128'(e.req));
                chk("gnt_o", 128'(gnt_o), 128'(e.gnt));
                chk("payload_o", 128'(payload_o), 128'(e.pay));
                chk("r_valid_o", 128'(r_valid_o), 128'(e.rv));
                chk("r_rdata_o", 128'(r_rdata_o), 128'(e.rdata));
                chk("outstanding_o", 128'(outstanding_o), 128'(e.outs));
                chk("err_o", 128'(err_o), 128'(e.err));
            end
        end
    end

    initial begin
        repeat (2) drive(1'b1, '0, 1'b0, 1'b0);
        drive(1'b1, 4'hf, 1'b1, 1'b1);
        // Fill to full with all requesting, then drain in order.
        repeat (8) drive(1'b0, 4'hf, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 4'h0, 1'b0, 1'b1);
        // Stalled target, then two handshakes from 1010.
        repeat (3) drive(1'b0, 4'b1010, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 4'b1010, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 4'h0, 1'b0, 1'b1);
        // Simultaneous push and pop with one outstanding.
        drive(1'b0, 4'b0100, 1'b1, 1'b0);
        drive(1'b0, 4'b0100, 1'b1, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        // Response with nothing outstanding, then reset clears the error.
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 299) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0));
        end
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);

        @(negedge clk);
        req3 = 3'b100;
        gnt3 = 1'b1;
        #3 chk("n3_grant_last", 128'(gnt3_o), 128'(3'b100));
        @(negedge clk);
        req3 = 3'b101;
        #3 chk("n3_wrap_to_zero", 128'(gnt3_o), 128'(3'b001));
        chk("n3_outstanding", 128'(out3_o), 128'(2'd1));
        @(negedge clk);
        req3 = 3'b000;
        gnt3 = 1'b0;
        rv3  = 1'b1;
        #3 chk("n3_rvalid_first", 128'(rv3_o), 128'(3'b100));
        @(negedge clk);
        #3 chk("n3_rvalid_second", 128'(rv3_o), 128'(3'b001));
        chk("n3_err", 128'(err3_o), 128'(1'b0));
        @(negedge clk);
        rv3 = 1'b0;
        #5;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
